fetch_unit: RTL

Instruction-fetch stage of the MIPS pipeline. It owns the program counter and drives the synchronous instruction memory's enable, address, hold and flush inputs. It re-aligns the one-cycle-late memory output with the PC that fetched it and presents a validated instruction/PC pair to the decode stage. It also absorbs stalls from the hazard unit and redirects from branch/jump resolution.

---
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_unit.sv | 84 ++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction-memory port and decode-side outputs.
// The master modport is the fetch unit; the slave modport is the surrounding pipeline and memory.
interface fetch_unit_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        imem_cen;
  logic        imem_wen;
  logic [31:0] imem_addr;
  logic        imem_hold;
  logic        imem_flush;
  logic [31:0] imem_q;

  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        fetch_fault;

  modport master (
    input  stall, redirect, redirect_pc, imem_q,
    output imem_cen, imem_wen, imem_addr, imem_hold, imem_flush,
    output if_valid, if_instr, if_pc, if_pc4, fetch_fault
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_q,
    input  imem_cen, imem_wen, imem_addr, imem_hold, imem_flush,
    input  if_valid, if_instr, if_pc, if_pc4, fetch_fault
  );
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, drives the synchronous imem and re-aligns Q with its PC.
// Optional misaligned-redirect trap enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2,
    FAULT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;     // address currently presented to imem
  logic [31:0] qpc_q, qpc_d;   // PC of the word now on imem_q
  logic [31:0] target_pc;
  logic        misaligned;

  // Reading the full vector keeps the low bits live even when the trap is compiled out.
  assign target_pc  = bus.redirect_pc & 32'hFFFF_FFFC;
  assign misaligned = (bus.redirect_pc & 32'h0000_0003) != 32'h0;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    qpc_d   = qpc_q;
    if (bus.redirect) begin
      pc_d    = target_pc;
      state_d = REDIR;
`ifdef FETCH_ALIGN_CHECK_EN
      if (misaligned) state_d = FAULT;
`endif
    end else if (!bus.stall) begin
      case (state_q)
        BOOT, RUN, REDIR: begin
          pc_d    = pc_q + 32'd4;
          qpc_d   = pc_q;
          state_d = RUN;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      qpc_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      qpc_q   <= qpc_d;
    end
  end

  // Memory controls: flush wins over hold, so the two can never be asserted together.
  assign bus.imem_cen   = (state_q != FAULT);
  assign bus.imem_wen   = 1'b0;
  assign bus.imem_addr  = pc_q;
  assign bus.imem_flush = rst | bus.redirect;
  assign bus.imem_hold  = ~rst & ~bus.redirect & bus.stall;

  assign bus.if_valid = (state_q == RUN);
  assign bus.if_instr = (state_q == RUN) ? bus.imem_q : 32'h0;
  assign bus.if_pc    = qpc_q;
  assign bus.if_pc4   = qpc_q + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
  assign bus.fetch_fault = (state_q == FAULT);
`else
  assign bus.fetch_fault = 1'b0;
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
`endif

endmodule
